// File: rtl/dm_pkg.sv
// Shared definitions for the multi-cycle data-memory responder: FSM state
// encoding, legal byte-enable patterns and the request error check.
package dm_pkg;

    localparam int DM_DEPTH = 3072;
    localparam int ADDR_W   = $clog2(DM_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] BE_B0  = 4'b0001;
    localparam logic [3:0] BE_B1  = 4'b0010;
    localparam logic [3:0] BE_B2  = 4'b0100;
    localparam logic [3:0] BE_B3  = 4'b1000;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    // Writes only support naturally aligned byte, halfword and word lanes
    function automatic logic be_legal_write(input logic [3:0] be);
        return (be == BE_B0) || (be == BE_B1) || (be == BE_B2) || (be == BE_B3) ||
               (be == BE_HLO) || (be == BE_HHI) || (be == BE_W);
    endfunction

    // A request is rejected when out of range, misaligned, empty, or an
    // unsupported write lane pattern
    function automatic logic req_err(input logic [31:0] addr,
                                     input logic        we,
                                     input logic [3:0]  be,
                                     input int unsigned depth);
        logic [31:0] limit;
        limit = 32'(depth * 4);
        return (addr >= limit) || (addr[1:0] != 2'b00) || (be == 4'b0000) ||
               (we && !be_legal_write(be));
    endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge of write data into an existing word.
module dm_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] new_word
);

    // Take each byte from wdata where its enable is set, otherwise keep the old byte
    always_comb begin
        new_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                new_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one request, waits LAT cycles
// while stalling the pipeline, then performs the access and strobes a response.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int LAT   = 2,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             cap_we;
    logic [31:0]      cap_addr;
    logic [31:0]      cap_wdata;
    logic [3:0]       cap_be;
    logic [31:0]      cap_pc;

    logic [31:0]      mem [DEPTH];

    logic             src_we;
    logic [31:0]      src_addr;
    logic [31:0]      src_wdata;
    logic [3:0]       src_be;
    logic [31:0]      src_pc;
    logic             src_err;
    logic [IDX_W-1:0] idx;
    logic [31:0]      old_word;
    logic [31:0]      merged;
    logic             accept;
    logic             access;
    logic             do_write;

    // With LAT==1 the access happens on the accepting edge, before the
    // capture registers are loaded, so the live request is used in IDLE
    always_comb begin
        src_we    = cap_we;
        src_addr  = cap_addr;
        src_wdata = cap_wdata;
        src_be    = cap_be;
        src_pc    = cap_pc;
        if (state == ST_IDLE) begin
            src_we    = req_we;
            src_addr  = req_addr;
            src_wdata = req_wdata;
            src_be    = req_be;
            src_pc    = req_pc;
        end
        src_err  = req_err(src_addr, src_we, src_be, DEPTH);
        idx      = src_addr[IDX_W+1:2];
        old_word = (32'(idx) < 32'(DEPTH)) ? mem[idx] : 32'h0;
        accept   = (state == ST_IDLE) && req_valid;
        access   = (accept && (LAT == 1)) || ((state == ST_WAIT) && (cnt == '0));
        do_write = access && src_we && !src_err;
    end

    dm_byte_merge u_merge (
        .old_word (old_word),
        .wdata    (src_wdata),
        .be       (src_be),
        .new_word (merged)
    );

    // Handshake outputs are decoded straight from the state
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        stall      = accept || (state == ST_WAIT);
    end

    // Request FSM, capture registers and registered response data
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_be     <= '0;
            cap_pc     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_be    <= req_be;
                        cap_pc    <= req_pc;
                        if (LAT == 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_W'(LAT - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (access) begin
                resp_err   <= src_err;
                resp_rdata <= (src_err || src_we) ? 32'h0 : old_word;
            end
        end
    end

    // Word storage: cleared on reset, merged write on the response-entry edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[idx] <= merged;
        end
    end

`ifndef SYNTHESIS
    // Write log for tracing committed stores
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            $display("%0t pc=%08h *%08h <= %08h", $time, src_pc,
                     {src_addr[31:2], 2'b00}, merged);
        end
    end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (LAT=2 main instance, LAT=1
// instance for back-to-back throughput).
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata, req_pc;
    logic [3:0]  req_be;
    logic        req_ready, resp_valid, resp_err, stall;
    logic [31:0] resp_rdata;

    logic        b_req_valid, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata, b_req_pc;
    logic [3:0]  b_req_be;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_stall;
    logic [31:0] b_resp_rdata;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          stalls;
    logic        resp_stall;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(3072), .LAT(2), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_pc     (req_pc),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall      (stall)
    );

    dm_responder #(.DEPTH(3072), .LAT(1), .CNT_W(4)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_req_valid),
        .req_we     (b_req_we),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .req_be     (b_req_be),
        .req_pc     (b_req_pc),
        .req_ready  (b_req_ready),
        .resp_valid (b_resp_valid),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err),
        .stall      (b_stall)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    // One access on the LAT=2 instance; returns response data, error,
    // cycles from the accepting edge to resp_valid, and stalled cycles
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic [31:0] pc,
                                 output logic [31:0] rdata_o, output logic err_o,
                                 output int lat_o, output int stalls_o,
                                 output logic resp_stall_o);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req_pc    = pc;
        #1;
        stalls_o     = stall ? 1 : 0;
        lat_o        = 0;
        rdata_o      = 32'hxxxxxxxx;
        err_o        = 1'bx;
        resp_stall_o = 1'bx;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (lat_o < 20) begin
            lat_o++;
            if (resp_valid) begin
                rdata_o      = resp_rdata;
                err_o        = resp_err;
                resp_stall_o = stall;
                break;
            end
            stalls_o += stall ? 1 : 0;
            @(negedge clk);
        end
    endtask

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;
        req_pc      = '0;
        b_req_valid = 1'b0;
        b_req_we    = 1'b0;
        b_req_addr  = '0;
        b_req_wdata = '0;
        b_req_be    = '0;
        b_req_pc    = '0;

        // Reset for two cycles, then check idle outputs
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_rdata", resp_rdata, 32'h0);
        checkOutput("rst_err", 32'(resp_err), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);

        // Read of cleared memory: latency and stall shape
        applyStimulus(1'b0, 32'h10, 32'h0, 4'b1111, 32'h100, rd, er, lat, stalls, resp_stall);
        checkOutput("t1_rdata", rd, 32'h0);
        checkOutput("t1_err", 32'(er), 32'd0);
        checkOutput("t1_lat", 32'(lat), 32'd2);
        checkOutput("t1_stalls", 32'(stalls), 32'd2);
        checkOutput("t1_resp_stall", 32'(resp_stall), 32'd0);

        // Full word write then read back
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h104, rd, er, lat, stalls, resp_stall);
        checkOutput("t2_wr_rdata", rd, 32'h0);
        checkOutput("t2_wr_err", 32'(er), 32'd0);
        checkOutput("t2_wr_lat", 32'(lat), 32'd2);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'b1111, 32'h108, rd, er, lat, stalls, resp_stall);
        checkOutput("t2_rd", rd, 32'hDEADBEEF);

        // Low halfword merge, then top byte merge
        applyStimulus(1'b1, 32'h10, 32'h00001234, 4'b0011, 32'h10C, rd, er, lat, stalls, resp_stall);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'b1111, 32'h110, rd, er, lat, stalls, resp_stall);
        checkOutput("t3_half", rd, 32'hDEAD1234);
        applyStimulus(1'b1, 32'h10, 32'hAA000000, 4'b1000, 32'h114, rd, er, lat, stalls, resp_stall);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'b1111, 32'h118, rd, er, lat, stalls, resp_stall);
        checkOutput("t3_byte", rd, 32'hAAAD1234);

        // Error cases
        applyStimulus(1'b0, 32'h3001, 32'h0, 4'b1111, 32'h11C, rd, er, lat, stalls, resp_stall);
        checkOutput("t4_misalign_err", 32'(er), 32'd1);
        checkOutput("t4_misalign_rdata", rd, 32'h0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'b1111, 32'h120, rd, er, lat, stalls, resp_stall);
        checkOutput("t4_unchanged", rd, 32'hAAAD1234);
        applyStimulus(1'b1, 32'h3000, 32'h55555555, 4'b1111, 32'h124, rd, er, lat, stalls, resp_stall);
        checkOutput("t4_range_err", 32'(er), 32'd1);
        checkOutput("t4_range_lat", 32'(lat), 32'd2);
        applyStimulus(1'b1, 32'h14, 32'h77777777, 4'b0101, 32'h128, rd, er, lat, stalls, resp_stall);
        checkOutput("t4_be_write_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 32'h14, 32'h0, 4'b0000, 32'h12C, rd, er, lat, stalls, resp_stall);
        checkOutput("t4_be_zero_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 32'h14, 32'h0, 4'b1111, 32'h130, rd, er, lat, stalls, resp_stall);
        checkOutput("t4_be_unchanged", rd, 32'h0);
        checkOutput("t4_ok_err", 32'(er), 32'd0);
        applyStimulus(1'b1, 32'h2FFC, 32'hCAFEF00D, 4'b1111, 32'h134, rd, er, lat, stalls, resp_stall);
        checkOutput("t4_last_wr_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 32'h2FFC, 32'h0, 4'b1111, 32'h138, rd, er, lat, stalls, resp_stall);
        checkOutput("t4_last_rd", rd, 32'hCAFEF00D);

        // Reset during WAIT of a write aborts it
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h11111111;
        req_be    = 4'b1111;
        req_pc    = 32'h200;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5_wait_stall", 32'(stall), 32'd1);
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        checkOutput("t5_no_resp", 32'(resp_valid), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("t5_ready", 32'(req_ready), 32'd1);
        checkOutput("t5_no_resp2", 32'(resp_valid), 32'd0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'b1111, 32'h204, rd, er, lat, stalls, resp_stall);
        checkOutput("t5_mem20", rd, 32'h0);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'b1111, 32'h208, rd, er, lat, stalls, resp_stall);
        checkOutput("t5_mem10_cleared", rd, 32'h0);

        // LAT=1 back-to-back reads with req_valid held high
        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_we    = 1'b0;
        b_req_addr  = 32'h10;
        b_req_be    = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput($sformatf("t6_stall_%0d", i), 32'(b_stall), 32'(((i % 2) == 0) ? 1 : 0));
            checkOutput($sformatf("t6_resp_%0d", i), 32'(b_resp_valid), 32'(i % 2));
            if (b_resp_valid) begin
                checkOutput($sformatf("t6_rdata_%0d", i), b_resp_rdata, 32'h0);
            end
            @(negedge clk);
        end
        b_req_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
